// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: parallel-to-serial pattern transmitter.
// Captures DATA on an accepted START and shifts the low Leff bits out MSB-first on Y,
// one bit per CLK, with one cycle of latency. Frames may be chained with no gap.
// Optional feature macro: SERIAL_PATTERN_TX_PARITY_EN appends an even-parity bit
// (state PAR) after the data bits; DONE then marks the parity cycle.
module serial_pattern_tx #(
    parameter int unsigned W          = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic [W-1:0]               DATA,
    input  logic [$clog2(W+1)-1:0]     LEN,
    output logic                       Y,
    output logic                       Y_VALID,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int unsigned LW    = $clog2(W+1);
    localparam logic [LW-1:0] W_LEN = LW'(W);
    localparam logic [LW-1:0] ONE   = LW'(1);
    localparam logic [LW-1:0] TWO   = LW'(2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        ,
        PAR
`endif
    } state_t;

    state_t          state;
    // sreg holds the bits still to be sent; the bit currently on Y is already registered.
    logic [W-1:0]    sreg;
    // cnt counts the data bits remaining, including the one currently on Y.
    logic [LW-1:0]   cnt;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic            par;
`endif

    logic [LW-1:0]   leff;
    logic [W-1:0]    load;
    logic            accept;

    // Clamp LEN to 1..W, left-justify the pattern and decide whether START is taken.
    always_comb begin
        leff = LEN;
        if ((LEN == '0) || (LEN > W_LEN)) begin
            leff = W_LEN;
        end
        load   = DATA << (W_LEN - leff);
        accept = START && ((state == IDLE) || DONE);
    end

    // Frame sequencer: state, shift register, counter and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            Y       <= IDLE_LEVEL;
            Y_VALID <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (accept) begin
            state   <= SHIFT;
            Y       <= load[W-1];
            sreg    <= load << 1;
            cnt     <= leff;
            Y_VALID <= 1'b1;
            BUSY    <= 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            DONE    <= 1'b0;
            par     <= load[W-1];
`else
            DONE    <= (leff == ONE);
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt > ONE) begin
                        Y    <= sreg[W-1];
                        sreg <= sreg << 1;
                        cnt  <= cnt - ONE;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        par  <= par ^ sreg[W-1];
`else
                        DONE <= (cnt == TWO);
`endif
                    end else begin
                        cnt <= '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        state <= PAR;
                        Y     <= par;
                        DONE  <= 1'b1;
`else
                        state   <= IDLE;
                        Y       <= IDLE_LEVEL;
                        Y_VALID <= 1'b0;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    Y       <= IDLE_LEVEL;
                    Y_VALID <= 1'b0;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule
